// File: rtl/zeroriscy_defines.sv
// Shared encodings for the iterative multiply/divide unit: operator codes and FSM states.
package zeroriscy_defines;

    localparam logic [1:0] MD_OP_MULL = 2'b00;
    localparam logic [1:0] MD_OP_MULH = 2'b01;
    localparam logic [1:0] MD_OP_DIV  = 2'b10;
    localparam logic [1:0] MD_OP_REM  = 2'b11;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_ABS_A,
        MD_ABS_B,
        MD_COMP,
        MD_LAST,
        MD_CHANGE_SIGN,
        MD_FINISH
    } md_fsm_e;

endpackage

// File: rtl/zeroriscy_multdiv_iter.sv
// Iterative radix-2 multiplier / restoring divider that borrows the ALU adder.
// Operand ports are {value[31:0], carry_in}; alu_adder_ext_i[33] is carry out.
module zeroriscy_multdiv_iter
    import zeroriscy_defines::*;
#(
    parameter int unsigned MD_ITER = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mult_en_i,
    input  logic        div_en_i,
    input  logic [1:0]  operator_i,
    input  logic [1:0]  signed_mode_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic [33:0] alu_adder_ext_i,
    output logic [32:0] alu_operand_a_o,
    output logic [32:0] alu_operand_b_o,
    output logic        multdiv_en_o,
    output logic [31:0] multdiv_result_o,
    output logic        ready_o
);

    md_fsm_e     state, state_next;
    logic [32:0] acc;
    logic [31:0] opa, opb;
    logic [5:0]  cnt;
    logic        neg_a, neg_b, div_zero;

    logic        busy;
    logic [31:0] sum;
    logic        carry;
    logic        adder_lsb_unused;
    logic        a_signed, b_signed;
    logic        mul_sub, mul_top;
    logic [31:0] mul_pp;
    logic [32:0] mul_acc_next;
    logic [31:0] mul_low_next;
    logic [31:0] div_rem_shift;
    logic        div_ge;
    logic [31:0] neg_val;
    logic        neg_result;

    assign busy             = mult_en_i | div_en_i;
    assign multdiv_en_o     = busy;
    assign sum              = alu_adder_ext_i[32:1];
    assign carry            = alu_adder_ext_i[33];
    assign adder_lsb_unused = alu_adder_ext_i[0];

    // Mode 2'b10 is unsigned x unsigned, so op_b only counts as signed when op_a is too.
    assign a_signed = signed_mode_i[0];
    assign b_signed = &signed_mode_i;

    // Shift-add step: the 33rd sum bit is rebuilt from the operand extension bits and carry out.
    assign mul_sub      = (state == MD_LAST) & b_signed & opb[0];
    assign mul_pp       = opb[0] ? (mul_sub ? ~opa : opa) : '0;
    assign mul_top      = acc[32] ^ (a_signed & mul_pp[31]) ^ carry;
    assign mul_acc_next = {a_signed & mul_top, mul_top, sum[31:1]};
    assign mul_low_next = {sum[0], opb[31:1]};

    // Restoring step: the partial remainder's MSB is the 33rd bit of the trial subtraction.
    assign div_rem_shift = {acc[30:0], opa[31]};
    assign div_ge        = acc[31] | carry;

    assign neg_val    = (operator_i == MD_OP_DIV) ? opa : acc[31:0];
    assign neg_result = (operator_i == MD_OP_DIV) ? ((neg_a ^ neg_b) & ~div_zero) : neg_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            MD_IDLE: begin
                if (mult_en_i) begin
                    state_next = MD_COMP;
                end else if (div_en_i) begin
                    state_next = MD_ABS_A;
                end
            end
            MD_ABS_A:       state_next = MD_ABS_B;
            MD_ABS_B:       state_next = MD_COMP;
            MD_COMP:        if (cnt == 6'd1) state_next = MD_LAST;
            MD_LAST:        state_next = div_en_i ? MD_CHANGE_SIGN : MD_FINISH;
            MD_CHANGE_SIGN: state_next = MD_FINISH;
            MD_FINISH:      state_next = MD_IDLE;
            default:        state_next = MD_IDLE;
        endcase
        if (state != MD_IDLE && !busy) begin
            state_next = MD_IDLE;
        end
    end

    always_comb begin
        alu_operand_a_o  = '0;
        alu_operand_b_o  = '0;
        ready_o          = 1'b0;
        multdiv_result_o = '0;
        if (rst_n) begin
            unique case (state)
                MD_ABS_A: begin
                    alu_operand_a_o = {32'h0, 1'b1};
                    alu_operand_b_o = {~op_a_i, 1'b1};
                end
                MD_ABS_B: begin
                    alu_operand_a_o = {32'h0, 1'b1};
                    alu_operand_b_o = {~op_b_i, 1'b1};
                end
                MD_COMP, MD_LAST: begin
                    if (div_en_i) begin
                        alu_operand_a_o = {div_rem_shift, 1'b1};
                        alu_operand_b_o = {~opb, 1'b1};
                    end else begin
                        alu_operand_a_o = {acc[31:0], mul_sub};
                        alu_operand_b_o = {mul_pp, mul_sub};
                    end
                end
                MD_CHANGE_SIGN: begin
                    alu_operand_a_o = {32'h0, 1'b1};
                    alu_operand_b_o = {~neg_val, 1'b1};
                end
                MD_FINISH: begin
                    ready_o = 1'b1;
                    unique case (operator_i)
                        MD_OP_MULL: multdiv_result_o = opb;
                        MD_OP_MULH: multdiv_result_o = acc[31:0];
                        MD_OP_DIV:  multdiv_result_o = opa;
                        default:    multdiv_result_o = acc[31:0];
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            opa      <= '0;
            opb      <= '0;
            cnt      <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            unique case (state)
                MD_IDLE: begin
                    if (busy) begin
                        acc      <= '0;
                        opa      <= op_a_i;
                        opb      <= op_b_i;
                        cnt      <= 6'(MD_ITER - 1);
                        neg_a    <= signed_mode_i[0] & op_a_i[31];
                        neg_b    <= signed_mode_i[1] & op_b_i[31];
                        div_zero <= (op_b_i == '0);
                    end
                end
                MD_ABS_A: opa <= neg_a ? sum : op_a_i;
                MD_ABS_B: opb <= neg_b ? sum : op_b_i;
                MD_COMP, MD_LAST: begin
                    cnt <= cnt - 6'd1;
                    if (div_en_i) begin
                        acc <= {1'b0, div_ge ? sum : div_rem_shift};
                        opa <= {opa[30:0], div_ge};
                    end else begin
                        acc <= mul_acc_next;
                        opb <= mul_low_next;
                    end
                end
                MD_CHANGE_SIGN: begin
                    if (neg_result) begin
                        if (operator_i == MD_OP_DIV) begin
                            opa <= sum;
                        end else begin
                            acc <= {1'b0, sum};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_zeroriscy_multdiv_iter.sv
// Bench for zeroriscy_multdiv_iter: models the ALU adder and checks results against 64-bit arithmetic.
module tb_zeroriscy_multdiv_iter;
    import zeroriscy_defines::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mult_en = 1'b0;
    logic        div_en = 1'b0;
    logic [1:0]  operator = '0;
    logic [1:0]  signed_mode = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [33:0] alu_adder_ext;
    logic [32:0] alu_operand_a, alu_operand_b;
    logic        multdiv_en, ready;
    logic [31:0] result;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    // Shared ALU adder as seen from the block: plain 34-bit sum of the two operand buses.
    assign alu_adder_ext = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};

    always #5 clk = ~clk;

    zeroriscy_multdiv_iter #(.MD_ITER(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mult_en_i        (mult_en),
        .div_en_i         (div_en),
        .operator_i       (operator),
        .signed_mode_i    (signed_mode),
        .op_a_i           (op_a),
        .op_b_i           (op_b),
        .alu_adder_ext_i  (alu_adder_ext),
        .alu_operand_a_o  (alu_operand_a),
        .alu_operand_b_o  (alu_operand_b),
        .multdiv_en_o     (multdiv_en),
        .multdiv_result_o (result),
        .ready_o          (ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [1:0] mode,
                                          input logic [31:0] a, input logic [31:0] b);
        longint      av, bv, q, r;
        logic [63:0] p;
        if (!op[1]) begin
            av = mode[0] ? longint'($signed(a)) : longint'({32'h0, a});
            bv = (mode == 2'b11) ? longint'($signed(b)) : longint'({32'h0, b});
            p  = 64'(av * bv);
            return (op == MD_OP_MULL) ? p[31:0] : p[63:32];
        end
        if (b == 32'h0) begin
            q = longint'(32'hFFFF_FFFF);
            r = longint'({32'h0, a});
        end else if (mode == 2'b11) begin
            av = longint'($signed(a));
            bv = longint'($signed(b));
            q  = av / bv;
            r  = av % bv;
        end else begin
            av = longint'({32'h0, a});
            bv = longint'({32'h0, b});
            q  = av / bv;
            r  = av % bv;
        end
        return (op == MD_OP_DIV) ? q[31:0] : r[31:0];
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [1:0] mode, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input string tag);
        int unsigned cyc;
        int unsigned lat;
        lat = op[1] ? 36 : 33;
        @(negedge clk);
        operator    = op;
        signed_mode = mode;
        op_a        = a;
        op_b        = b;
        mult_en     = ~op[1];
        div_en      = op[1];
        #1;
        check({tag, "/en"}, 64'(multdiv_en), 64'd1);
        check({tag, "/res_idle"}, 64'(result), 64'd0);
        cyc = 0;
        while (!ready && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "/latency"}, 64'(cyc), 64'(lat));
        check({tag, "/result"}, 64'(result), 64'(exp));
        mult_en = 1'b0;
        div_en  = 1'b0;
        @(negedge clk);
        check({tag, "/pulse"}, 64'(ready), 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        unique case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic        saw_ready;
        logic [1:0]  op, mode;
        logic [31:0] a, b;

        repeat (3) @(negedge clk);
        check("reset/ready", 64'(ready), 64'd0);
        check("reset/result", 64'(result), 64'd0);
        check("reset/alu_a", 64'(alu_operand_a), 64'd0);
        check("reset/alu_b", 64'(alu_operand_b), 64'd0);
        check("reset/en", 64'(multdiv_en), 64'd0);
        rst_n = 1'b1;

        run_op(MD_OP_MULL, 2'b11, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mull_7x-3");
        run_op(MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ff");
        run_op(MD_OP_MULH, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_ff");
        run_op(MD_OP_MULH, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ff");
        run_op(MD_OP_MULH, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulh_m10");
        run_op(MD_OP_DIV,  2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_-7/2");
        run_op(MD_OP_REM,  2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_-7/2");
        run_op(MD_OP_DIV,  2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_5/0");
        run_op(MD_OP_REM,  2'b00, 32'd5, 32'd0, 32'd5, "remu_5/0");
        run_op(MD_OP_REM,  2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, "rem_-7/0");
        run_op(MD_OP_DIV,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run_op(MD_OP_REM,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "rem_ovf");

        // Divide dropped in cycle 10: no completion pulse afterwards.
        @(negedge clk);
        operator    = MD_OP_DIV;
        signed_mode = 2'b11;
        op_a        = 32'd100;
        op_b        = 32'd7;
        div_en      = 1'b1;
        saw_ready   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready) saw_ready = 1'b1;
        end
        div_en = 1'b0;
        @(negedge clk);
        check("abort/en", 64'(multdiv_en), 64'd0);
        for (int i = 0; i < 40; i++) begin
            if (ready) saw_ready = 1'b1;
            @(negedge clk);
        end
        check("abort/no_ready", 64'(saw_ready), 64'd0);
        run_op(MD_OP_MULL, 2'b00, 32'd6, 32'd9, 32'd54, "after_abort");

        // Reset pulsed in the middle of a multiply.
        @(negedge clk);
        operator    = MD_OP_MULL;
        signed_mode = 2'b00;
        op_a        = 32'h0123_4567;
        op_b        = 32'h89AB_CDEF;
        mult_en     = 1'b1;
        repeat (15) @(negedge clk);
        check("rst_mid/busy", 64'(multdiv_en), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid/ready", 64'(ready), 64'd0);
        check("rst_mid/result", 64'(result), 64'd0);
        check("rst_mid/alu_a", 64'(alu_operand_a), 64'd0);
        check("rst_mid/alu_b", 64'(alu_operand_b), 64'd0);
        mult_en = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        saw_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) saw_ready = 1'b1;
        end
        check("rst_mid/no_ready", 64'(saw_ready), 64'd0);
        run_op(MD_OP_MULL, 2'b00, 32'd3, 32'd4, 32'd12, "mull_3x4");

        for (int i = 0; i < 40; i++) begin
            op   = 2'($urandom_range(0, 3));
            mode = op[1] ? ($urandom_range(0, 1) ? 2'b11 : 2'b00) : 2'($urandom_range(0, 3));
            a    = pick_operand();
            b    = pick_operand();
            run_op(op, mode, a, b, model(op, mode, a, b), $sformatf("rnd%0d_op%0d_m%0d", i, op, mode));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

endmodule
